// File: rtl/i2s_frame_sched_pkg.sv
// Shared types and constants for the I2S transmit frame scheduler.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } sched_state_t;

  localparam logic CHAN_L = 1'b0;
  localparam logic CHAN_R = 1'b1;
  localparam int   UCNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/i2s_frame_sched_if.sv
// Upstream frame stream and downstream sample handshake of the scheduler.
// The master modport is the scheduler side; slave is the FIFO/serializer side.
interface i2s_frame_sched_if #(
  parameter int DW = 24
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_sample;
  logic          o_chan;

  modport master (
    input  s_valid, s_left, s_right, i_ready,
    output s_ready, o_valid, o_sample, o_chan
  );

  modport slave (
    output s_valid, s_left, s_right, i_ready,
    input  s_ready, o_valid, o_sample, o_chan
  );
endinterface

// File: rtl/i2s_frame_ctr.sv
// Modulo-FS_RATIO frame position counter with enable and synchronous clear.
// Wrap and half strobes flag the last cycle of the frame and of its first half.
module i2s_frame_ctr #(
  parameter int FS_RATIO = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic                        i_clr,
  output logic [$clog2(FS_RATIO)-1:0] o_fc,
  output logic                        o_wrap,
  output logic                        o_half
);
  localparam int             FCW     = $clog2(FS_RATIO);
  localparam logic [FCW-1:0] LAST    = FCW'(FS_RATIO - 1);
  localparam logic [FCW-1:0] HALF_M1 = FCW'(FS_RATIO / 2 - 1);

  logic [FCW-1:0] fc_q, fc_d;

  assign o_wrap = i_en && (fc_q == LAST);
  assign o_half = i_en && (fc_q == HALF_M1);
  assign o_fc   = fc_q;

  always_comb begin
    fc_d = fc_q;
    if (i_clr || o_wrap) fc_d = '0;
    else if (i_en)       fc_d = fc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fc_q <= '0;
    else        fc_q <= fc_d;
  end
endmodule

// File: rtl/i2s_frame_sched.sv
// I2S transmit frame scheduler: pulls one stereo frame per frame period and
// offers left then right to the serializer, handling stop, mute and underrun.
//   state | meaning
//   IDLE  | stopped, counter held at 0
//   WAIT  | enabled, waiting for the first upstream frame
//   RUN   | streaming, one frame pulled (or substituted) at fc=0
//   STOP  | finishing the current frame, then back to IDLE
module i2s_frame_sched
  import i2s_pkg::*;
#(
  parameter int DW        = 24,
  parameter int FS_RATIO  = 256,
  parameter int HOLD_LAST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_mute,
  input  logic              i_clr_stats,
  i2s_frame_sched_if.master bus,
  output logic              o_frame_start,
  output logic              o_underrun,
  output logic              o_late,
  output logic [UCNT_W-1:0] o_underrun_cnt,
  output logic              o_busy
);
  localparam int FCW = $clog2(FS_RATIO);

  sched_state_t      state_q, state_d;
  logic [FCW-1:0]    fc;
  logic              fc_en, fc_clr, fc_wrap, fc_half, fc_zero;
  logic              s_ready, take, underrun, load;
  logic [DW-1:0]     buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic              mute_q, mute_d;
  logic              o_valid_q, o_valid_d, o_chan_q, o_chan_d;
  logic [DW-1:0]     o_sample_q, o_sample_d;
  logic              frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic              late_q, late_d, busy_q, busy_d;
  logic [UCNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

  i2s_frame_ctr #(.FS_RATIO(FS_RATIO)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (fc_en),
    .i_clr  (fc_clr),
    .o_fc   (fc),
    .o_wrap (fc_wrap),
    .o_half (fc_half)
  );

  assign fc_zero  = (fc == '0);
  assign s_ready  = (state_q == WAIT) || ((state_q == RUN) && fc_zero);
  assign take     = s_ready && bus.s_valid;
  assign underrun = (state_q == RUN) && fc_zero && !bus.s_valid;
  assign load     = take || underrun;

  // The WAIT handshake cycle is frame position 0, so the counter steps with it.
  assign fc_en  = (state_q == RUN) || (state_q == STOP) || ((state_q == WAIT) && bus.s_valid);
  assign fc_clr = (state_q == IDLE) || ((state_q == WAIT) && !bus.s_valid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = WAIT;
      WAIT: begin
        if (bus.s_valid)    state_d = RUN;
        else if (!i_enable) state_d = IDLE;
      end
      RUN:     if (!i_enable) state_d = STOP;
      STOP:    if (fc_wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_l_d        = buf_l_q;
    buf_r_d        = buf_r_q;
    mute_d         = mute_q;
    underrun_cnt_d = underrun_cnt_q;
    // Buffers keep the raw frame; mute is applied on the way out.
    if (take) begin
      buf_l_d = bus.s_left;
      buf_r_d = bus.s_right;
      mute_d  = i_mute;
    end else if (underrun) begin
      if (HOLD_LAST == 0) begin
        buf_l_d = '0;
        buf_r_d = '0;
      end
      mute_d = i_mute;
    end
    if (underrun)         underrun_cnt_d = i_clr_stats ? UCNT_W'(1) : sat_inc(underrun_cnt_q);
    else if (i_clr_stats) underrun_cnt_d = '0;
  end

  always_comb begin
    o_valid_d  = o_valid_q && !bus.i_ready;
    o_chan_d   = o_chan_q;
    o_sample_d = o_sample_q;
    late_d     = 1'b0;
    // Right is offered on schedule even if left is still pending.
    if (fc_half) begin
      late_d     = o_valid_q && !bus.i_ready;
      o_valid_d  = 1'b1;
      o_chan_d   = CHAN_R;
      o_sample_d = mute_q ? '0 : buf_r_q;
    end else if (fc_wrap) begin
      late_d    = o_valid_q && !bus.i_ready;
      o_valid_d = 1'b0;
    end
    if (load) begin
      o_valid_d  = 1'b1;
      o_chan_d   = CHAN_L;
      o_sample_d = mute_d ? '0 : buf_l_d;
    end
    frame_start_d = load;
    underrun_d    = underrun;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      buf_l_q        <= '0;
      buf_r_q        <= '0;
      mute_q         <= 1'b0;
      o_valid_q      <= 1'b0;
      o_chan_q       <= CHAN_L;
      o_sample_q     <= '0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      late_q         <= 1'b0;
      busy_q         <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      buf_l_q        <= buf_l_d;
      buf_r_q        <= buf_r_d;
      mute_q         <= mute_d;
      o_valid_q      <= o_valid_d;
      o_chan_q       <= o_chan_d;
      o_sample_q     <= o_sample_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      late_q         <= late_d;
      busy_q         <= busy_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_chan     = o_chan_q;
  assign bus.o_sample   = o_sample_q;
  assign o_frame_start  = frame_start_q;
  assign o_underrun     = underrun_q;
  assign o_late         = late_q;
  assign o_underrun_cnt = underrun_cnt_q;
  assign o_busy         = busy_q;
endmodule

// File: tb/tb_i2s_frame_sched.sv
// Directed bench for i2s_frame_sched at FS_RATIO=16, DW=24; dut0 substitutes
// zeros on underrun, dut1 repeats the last frame. Both see identical stimulus.
module tb_i2s_frame_sched;
  import i2s_pkg::*;

  logic clk, rst_n, i_enable, i_mute, i_clr_stats;
  logic s_valid, i_ready;
  logic [23:0] s_left, s_right;
  logic fs0, ur0, late0, busy0, fs1, ur1, late1, busy1;
  logic [15:0] cnt0, cnt1;
  int checks = 0;
  int passed = 0;
  int exp_fc = 0;
  bit running = 0;

  i2s_frame_sched_if #(.DW(24)) bus0 ();
  i2s_frame_sched_if #(.DW(24)) bus1 ();

  assign bus0.s_valid = s_valid;
  assign bus0.s_left  = s_left;
  assign bus0.s_right = s_right;
  assign bus0.i_ready = i_ready;
  assign bus1.s_valid = s_valid;
  assign bus1.s_left  = s_left;
  assign bus1.s_right = s_right;
  assign bus1.i_ready = i_ready;

  i2s_frame_sched #(.DW(24), .FS_RATIO(16), .HOLD_LAST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_mute(i_mute),
    .i_clr_stats(i_clr_stats), .bus(bus0), .o_frame_start(fs0),
    .o_underrun(ur0), .o_late(late0), .o_underrun_cnt(cnt0), .o_busy(busy0)
  );

  i2s_frame_sched #(.DW(24), .FS_RATIO(16), .HOLD_LAST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_mute(i_mute),
    .i_clr_stats(i_clr_stats), .bus(bus1), .o_frame_start(fs1),
    .o_underrun(ur1), .o_late(late1), .o_underrun_cnt(cnt1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are read and inputs changed 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    if (running) exp_fc = (exp_fc + 1) % 16;
  endtask

  task automatic goto_fc(input int k);
    repeat ((k - exp_fc + 16) % 16) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b0; i_mute = 1'b0; i_clr_stats = 1'b0;
    s_valid = 1'b0; i_ready = 1'b1; s_left = '0; s_right = '0;
    repeat (3) tick();
    checks++; if (bus0.s_ready !== 1'b0 || bus1.s_ready !== 1'b0) $display("FAIL rst_s_ready got=%b%b exp=00", bus0.s_ready, bus1.s_ready); else passed++;
    checks++; if ({bus0.o_valid, bus0.o_chan, fs0, ur0, late0, busy0} !== 6'b0) $display("FAIL rst_flags0 got=%b exp=000000", {bus0.o_valid, bus0.o_chan, fs0, ur0, late0, busy0}); else passed++;
    checks++; if ({bus1.o_valid, bus1.o_chan, fs1, ur1, late1, busy1} !== 6'b0) $display("FAIL rst_flags1 got=%b exp=000000", {bus1.o_valid, bus1.o_chan, fs1, ur1, late1, busy1}); else passed++;
    checks++; if (bus0.o_sample !== 24'h0 || bus1.o_sample !== 24'h0 || cnt0 !== 16'h0 || cnt1 !== 16'h0) $display("FAIL rst_data got=%h %h %h %h exp=0", bus0.o_sample, bus1.o_sample, cnt0, cnt1); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if (busy0 !== 1'b0 || bus0.s_ready !== 1'b0) $display("FAIL rst_idle got=%b%b exp=00", busy0, bus0.s_ready); else passed++;
  endtask

  task automatic test_basic();
    int n_fs;
    i_enable = 1'b1; i_ready = 1'b1; s_valid = 1'b1; s_left = 24'h123456; s_right = 24'hABCDEF;
    tick();
    checks++; if (bus0.s_ready !== 1'b1 || busy0 !== 1'b1) $display("FAIL t1_wait got=%b%b exp=11", bus0.s_ready, busy0); else passed++;
    running = 1'b1;
    tick();
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_L || bus0.o_sample !== 24'h123456) $display("FAIL t1_left got=%b %b %h exp=1 0 123456", bus0.o_valid, bus0.o_chan, bus0.o_sample); else passed++;
    checks++; if (fs0 !== 1'b1 || bus0.s_ready !== 1'b0) $display("FAIL t1_fs got=%b%b exp=10", fs0, bus0.s_ready); else passed++;
    s_left = 24'h111111; s_right = 24'h222222;
    tick();
    checks++; if (bus0.o_valid !== 1'b0 || fs0 !== 1'b0) $display("FAIL t1_ack got=%b%b exp=00", bus0.o_valid, fs0); else passed++;
    goto_fc(7);
    checks++; if (bus0.o_valid !== 1'b0) $display("FAIL t1_pre_right got=%b exp=0", bus0.o_valid); else passed++;
    tick();
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_R || bus0.o_sample !== 24'hABCDEF) $display("FAIL t1_right got=%b %b %h exp=1 1 abcdef", bus0.o_valid, bus0.o_chan, bus0.o_sample); else passed++;
    n_fs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (fs0 === 1'b1) n_fs++;
    end
    checks++; if (n_fs !== 1) $display("FAIL t1_fs_rate got=%0d exp=1", n_fs); else passed++;
    checks++; if (bus0.o_sample !== 24'h222222 || bus0.o_chan !== CHAN_R) $display("FAIL t1_right2 got=%h %b exp=222222 1", bus0.o_sample, bus0.o_chan); else passed++;
  endtask

  task automatic test_underrun();
    goto_fc(0);
    checks++; if (bus0.s_ready !== 1'b1) $display("FAIL t2_ready_fc0 got=%b exp=1", bus0.s_ready); else passed++;
    s_valid = 1'b0;
    tick();
    checks++; if (ur0 !== 1'b1 || ur1 !== 1'b1) $display("FAIL t2_pulse got=%b%b exp=11", ur0, ur1); else passed++;
    checks++; if (bus0.o_sample !== 24'h0 || bus1.o_sample !== 24'h111111) $display("FAIL t2_left got=%h %h exp=000000 111111", bus0.o_sample, bus1.o_sample); else passed++;
    checks++; if (cnt0 !== 16'd1 || cnt1 !== 16'd1) $display("FAIL t2_cnt got=%0d %0d exp=1 1", cnt0, cnt1); else passed++;
    tick();
    checks++; if (ur0 !== 1'b0) $display("FAIL t2_pulse_len got=%b exp=0", ur0); else passed++;
    goto_fc(8);
    checks++; if (bus0.o_sample !== 24'h0 || bus1.o_sample !== 24'h222222 || bus1.o_chan !== CHAN_R) $display("FAIL t2_right got=%h %h %b exp=000000 222222 1", bus0.o_sample, bus1.o_sample, bus1.o_chan); else passed++;
  endtask

  task automatic test_saturate();
    force dut0.underrun_cnt_q = 16'hFFFE;
    tick();
    release dut0.underrun_cnt_q;
    checks++; if (cnt0 !== 16'hFFFE) $display("FAIL t3_preload got=%h exp=fffe", cnt0); else passed++;
    for (int i = 0; i < 3; i++) begin
      goto_fc(0);
      tick();
      checks++; if (cnt0 !== 16'hFFFF) $display("FAIL t3_sat%0d got=%h exp=ffff", i, cnt0); else passed++;
      checks++; if (cnt1 !== 16'(2 + i)) $display("FAIL t3_cnt1_%0d got=%0d exp=%0d", i, cnt1, 2 + i); else passed++;
    end
    goto_fc(0);
    i_clr_stats = 1'b1;
    tick();
    i_clr_stats = 1'b0;
    checks++; if (cnt0 !== 16'd1 || cnt1 !== 16'd1) $display("FAIL t3_clr_ur got=%0d %0d exp=1 1", cnt0, cnt1); else passed++;
    i_clr_stats = 1'b1;
    tick();
    i_clr_stats = 1'b0;
    checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) $display("FAIL t3_clr got=%0d %0d exp=0 0", cnt0, cnt1); else passed++;
  endtask

  task automatic test_late();
    i_ready = 1'b0; s_valid = 1'b1; s_left = 24'h0A0A0A; s_right = 24'h0B0B0B;
    goto_fc(0);
    tick();
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_L || bus0.o_sample !== 24'h0A0A0A || late0 !== 1'b0) $display("FAIL t4_left got=%b %b %h %b exp=1 0 0a0a0a 0", bus0.o_valid, bus0.o_chan, bus0.o_sample, late0); else passed++;
    goto_fc(7);
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_sample !== 24'h0A0A0A || late0 !== 1'b0) $display("FAIL t4_hold got=%b %h %b exp=1 0a0a0a 0", bus0.o_valid, bus0.o_sample, late0); else passed++;
    tick();
    checks++; if (late0 !== 1'b1 || bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_R || bus0.o_sample !== 24'h0B0B0B) $display("FAIL t4_late_l got=%b %b %b %h exp=1 1 1 0b0b0b", late0, bus0.o_valid, bus0.o_chan, bus0.o_sample); else passed++;
    tick();
    checks++; if (late0 !== 1'b0 || bus0.o_valid !== 1'b1) $display("FAIL t4_after got=%b%b exp=01", late0, bus0.o_valid); else passed++;
    goto_fc(0);
    checks++; if (late0 !== 1'b1 || bus0.o_valid !== 1'b0) $display("FAIL t4_late_r got=%b%b exp=10", late0, bus0.o_valid); else passed++;
    tick();
    checks++; if (late0 !== 1'b0 || bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_L) $display("FAIL t4_next got=%b %b %b exp=0 1 0", late0, bus0.o_valid, bus0.o_chan); else passed++;
    i_ready = 1'b1;
    tick();
    checks++; if (bus0.o_valid !== 1'b0 || late0 !== 1'b0) $display("FAIL t4_accept got=%b%b exp=00", bus0.o_valid, late0); else passed++;
  endtask

  task automatic test_stop();
    s_left = 24'h333333; s_right = 24'h444444;
    goto_fc(0);
    tick();
    checks++; if (bus0.o_sample !== 24'h333333) $display("FAIL t5_left got=%h exp=333333", bus0.o_sample); else passed++;
    goto_fc(3);
    i_enable = 1'b0;
    tick();
    checks++; if (busy0 !== 1'b1 || bus0.s_ready !== 1'b0) $display("FAIL t5_stop got=%b%b exp=10", busy0, bus0.s_ready); else passed++;
    goto_fc(5);
    i_enable = 1'b1;
    goto_fc(8);
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_R || bus0.o_sample !== 24'h444444) $display("FAIL t5_right got=%b %b %h exp=1 1 444444", bus0.o_valid, bus0.o_chan, bus0.o_sample); else passed++;
    goto_fc(15);
    checks++; if (busy0 !== 1'b1) $display("FAIL t5_busy got=%b exp=1", busy0); else passed++;
    tick();
    checks++; if (busy0 !== 1'b0 || bus0.s_ready !== 1'b0 || fs0 !== 1'b0 || bus0.o_valid !== 1'b0) $display("FAIL t5_idle got=%b %b %b %b exp=0 0 0 0", busy0, bus0.s_ready, fs0, bus0.o_valid); else passed++;
    i_enable = 1'b0;
    running = 1'b0;
    exp_fc = 0;
    tick();
    checks++; if (busy0 !== 1'b0 || bus0.s_ready !== 1'b0) $display("FAIL t5_stay got=%b%b exp=00", busy0, bus0.s_ready); else passed++;
  endtask

  task automatic test_mute_reset();
    i_enable = 1'b1; i_mute = 1'b1; s_valid = 1'b1; s_left = 24'h7FFFFF; s_right = 24'h800000;
    tick();
    checks++; if (bus0.s_ready !== 1'b1) $display("FAIL t6_wait got=%b exp=1", bus0.s_ready); else passed++;
    running = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_sample !== 24'h0 || fs0 !== 1'b1 || bus0.s_ready !== 1'b0) $display("FAIL t6_mute_l got=%b %h %b %b exp=1 000000 1 0", bus0.o_valid, bus0.o_sample, fs0, bus0.s_ready); else passed++;
    goto_fc(8);
    checks++; if (bus0.o_valid !== 1'b1 || bus0.o_chan !== CHAN_R || bus0.o_sample !== 24'h0) $display("FAIL t6_mute_r got=%b %b %h exp=1 1 000000", bus0.o_valid, bus0.o_chan, bus0.o_sample); else passed++;
    goto_fc(10);
    rst_n = 1'b0;
    running = 1'b0;
    tick();
    checks++; if ({bus0.o_valid, bus0.o_chan, fs0, ur0, late0, busy0, bus0.s_ready} !== 7'b0) $display("FAIL t6_rst_flags got=%b exp=0000000", {bus0.o_valid, bus0.o_chan, fs0, ur0, late0, busy0, bus0.s_ready}); else passed++;
    checks++; if (bus0.o_sample !== 24'h0 || cnt0 !== 16'h0) $display("FAIL t6_rst_data got=%h %h exp=0 0", bus0.o_sample, cnt0); else passed++;
    i_enable = 1'b0; i_mute = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (busy0 !== 1'b0 || bus0.o_valid !== 1'b0) $display("FAIL t6_idle got=%b%b exp=00", busy0, bus0.o_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_saturate();
    test_late();
    test_stop();
    test_mute_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
